// File: rtl/enc_readout_pkg.sv
`default_nettype none
// ============================================================================
// Module      : enc_readout_pkg
// Description : Shared types and constants for the encoder readout arbiter:
//               FSM state encoding, default counter geometry and the
//               snapshot byte-count derivation.
// Revision    : 1.0  initial release
// ============================================================================
package enc_readout_pkg;

    // Default geometry: four 16-bit encoder counters.
    localparam int c_DEFAULT_NCNT  = 4;
    localparam int c_DEFAULT_WIDTH = 16;

    // Arbiter FSM: IDLE waits for a snapshot, SERVE streams its bytes out.
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_SERVE = 1'b1
    } state_t;

    // Number of bytes in one snapshot (WIDTH is always a multiple of 8).
    function automatic int nbytes(input int ncnt, input int width);
        return (ncnt * width) / 8;
    endfunction

endpackage : enc_readout_pkg
`default_nettype wire

// File: rtl/enc_snapshot_bank.sv
`default_nettype none
// ============================================================================
// Module      : enc_snapshot_bank
// Description : Snapshot register bank for the encoder readout arbiter.
//               Latches every counter on i_snap and presents the byte
//               selected by i_sel. With ENC_READOUT_DELTA_EN defined the
//               latched value is the difference to the previous snapshot
//               (modulo 2^WIDTH); otherwise it is the absolute count.
// Revision    : 1.0  initial release
// ============================================================================
module enc_snapshot_bank #(
    parameter int NCNT   = 4,
    parameter int WIDTH  = 16,
    parameter int NBYTES = 8,
    parameter int PTR_W  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCNT*WIDTH-1:0] i_cnt,
    input  logic                  i_snap,
    input  logic [PTR_W-1:0]      i_sel,
    output logic [7:0]            o_byte
);

    // Snapshot contents flattened so counter 0 sits in the low bytes and
    // each counter is little-endian; byte index == readout order.
    logic [NCNT*WIDTH-1:0] w_snap_flat;

    for (genvar k = 0; k < NCNT; k++) begin : g_cnt
        logic [WIDTH-1:0] w_live;
        logic [WIDTH-1:0] w_served;
        logic [WIDTH-1:0] r_snap;

        assign w_live = i_cnt[k*WIDTH +: WIDTH];

`ifdef ENC_READOUT_DELTA_EN
        logic [WIDTH-1:0] r_prev;

        // Unsigned subtraction wraps naturally, giving the signed delta.
        assign w_served = w_live - r_prev;

        // Remember the raw count of every snapshot as the next baseline.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_prev <= '0;
            end else if (i_snap) begin
                r_prev <= w_live;
            end
        end
`else
        assign w_served = w_live;
`endif

        // Latch the served value; it is frozen until the next snapshot.
        always_ff @(posedge clk) begin
            if (rst) begin
                r_snap <= '0;
            end else if (i_snap) begin
                r_snap <= w_served;
            end
        end

        assign w_snap_flat[k*WIDTH +: WIDTH] = r_snap;
    end

    // Byte-select mux driven by the arbiter's read pointer.
    always_comb begin
        o_byte = 8'h00;
        for (int b = 0; b < NBYTES; b++) begin
            if (i_sel == PTR_W'(b)) begin
                o_byte = w_snap_flat[b*8 +: 8];
            end
        end
    end

endmodule : enc_snapshot_bank
`default_nettype wire

// File: rtl/enc_readout_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : enc_readout_arbiter
// Description : Host readout arbiter for NCNT encoder counters. A snap_req
//               atomically latches all counters; rd_req then streams the
//               snapshot one byte per cycle (counter 0 first, little-endian)
//               with one cycle of latency. A read with nothing pending
//               returns rd_err and 0x00.
//               Optional macro: ENC_READOUT_DELTA_EN (serve deltas between
//               consecutive snapshots instead of absolute counts).
// Revision    : 1.0  initial release
// ============================================================================
module enc_readout_arbiter
    import enc_readout_pkg::*;
#(
    parameter int NCNT  = c_DEFAULT_NCNT,
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NCNT*WIDTH-1:0] cnt,
    input  logic                  snap_req,
    input  logic                  rd_req,
    output logic [7:0]            rd_data,
    output logic                  rd_valid,
    output logic                  rd_err,
    output logic                  busy
);

    localparam int c_NBYTES = nbytes(NCNT, WIDTH);
    localparam int c_PTR_W  = (c_NBYTES > 1) ? $clog2(c_NBYTES) : 1;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_PTR_W-1:0] r_ptr;
    logic [c_PTR_W-1:0] w_ptr_nxt;
    logic               w_snap;
    logic [7:0]         w_byte;
    logic [7:0]         r_rd_data;
    logic [7:0]         w_rd_data_nxt;
    logic               r_rd_valid;
    logic               w_rd_valid_nxt;
    logic               r_rd_err;
    logic               w_rd_err_nxt;

    enc_snapshot_bank #(
        .NCNT   (NCNT),
        .WIDTH  (WIDTH),
        .NBYTES (c_NBYTES),
        .PTR_W  (c_PTR_W)
    ) u_bank (
        .clk    (clk),
        .rst    (rst),
        .i_cnt  (cnt),
        .i_snap (w_snap),
        .i_sel  (r_ptr),
        .o_byte (w_byte)
    );

    // State, pointer and registered read-port outputs; reset beats everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= '0;
            r_rd_data  <= 8'h00;
            r_rd_valid <= 1'b0;
            r_rd_err   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_ptr      <= w_ptr_nxt;
            r_rd_data  <= w_rd_data_nxt;
            r_rd_valid <= w_rd_valid_nxt;
            r_rd_err   <= w_rd_err_nxt;
        end
    end

    // Next-state logic: snap_req wins over rd_req; reads advance the pointer
    // and the last byte returns the FSM to IDLE on the same edge.
    always_comb begin
        w_state_nxt    = r_state;
        w_ptr_nxt      = r_ptr;
        w_snap         = 1'b0;
        w_rd_data_nxt  = r_rd_data;
        w_rd_valid_nxt = 1'b0;
        w_rd_err_nxt   = 1'b0;

        if (snap_req) begin
            w_snap      = 1'b1;
            w_ptr_nxt   = '0;
            w_state_nxt = ST_SERVE;
        end else if (rd_req) begin
            case (r_state)
                ST_SERVE: begin
                    w_rd_data_nxt  = w_byte;
                    w_rd_valid_nxt = 1'b1;
                    if (r_ptr == c_PTR_W'(c_NBYTES - 1)) begin
                        w_ptr_nxt   = '0;
                        w_state_nxt = ST_IDLE;
                    end else begin
                        w_ptr_nxt = r_ptr + c_PTR_W'(1);
                    end
                end
                default: begin
                    w_rd_data_nxt = 8'h00;
                    w_rd_err_nxt  = 1'b1;
                end
            endcase
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign rd_err   = r_rd_err;
    assign busy     = (r_state == ST_SERVE);

endmodule : enc_readout_arbiter
`default_nettype wire

// File: tb/tb_enc_readout_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_readout_arbiter
// Description : Directed self-checking bench for enc_readout_arbiter with
//               NCNT=4, WIDTH=16. Expected bytes are hand-computed.
// Revision    : 1.0  initial release
// ============================================================================
module tb_enc_readout_arbiter;

    localparam int NCNT  = 4;
    localparam int WIDTH = 16;

    logic                  clk;
    logic                  rst;
    logic [NCNT*WIDTH-1:0] cnt;
    logic                  snap_req;
    logic                  rd_req;
    logic [7:0]            rd_data;
    logic                  rd_valid;
    logic                  rd_err;
    logic                  busy;

    int n_checks;
    int n_errors;

    enc_readout_arbiter #(
        .NCNT  (NCNT),
        .WIDTH (WIDTH)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .cnt      (cnt),
        .snap_req (snap_req),
        .rd_req   (rd_req),
        .rd_data  (rd_data),
        .rd_valid (rd_valid),
        .rd_err   (rd_err),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value.
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; return 1 ns after the edge so outputs are settled.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] exp_a [8];

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst      = 1'b1;
        cnt      = '0;
        snap_req = 1'b0;
        rd_req   = 1'b0;
        exp_a    = '{8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};

        cyc();
        cyc();
        rst = 1'b0;
        chk("reset_rd_data",  32'(rd_data),  32'h00);
        chk("reset_rd_valid", 32'(rd_valid), 32'h0);
        chk("reset_rd_err",   32'(rd_err),   32'h0);
        chk("reset_busy",     32'(busy),     32'h0);

        // Read with no snapshot pending.
        rd_req = 1'b1;
        cyc();
        rd_req = 1'b0;
        chk("idle_rd_err",   32'(rd_err),   32'h1);
        chk("idle_rd_valid", 32'(rd_valid), 32'h0);
        chk("idle_rd_data",  32'(rd_data),  32'h00);
        chk("idle_busy",     32'(busy),     32'h0);
        cyc();
        chk("idle_rd_err_pulse", 32'(rd_err), 32'h0);

        // Full 8-byte transfer; cnt changes after the snapshot must not leak in.
        cnt      = 64'h4444_3333_2222_1111;
        snap_req = 1'b1;
        cyc();
        snap_req = 1'b0;
        cnt      = 64'hFFFF_EEEE_DDDD_CCCC;
        chk("snap_busy",     32'(busy),     32'h1);
        chk("snap_rd_valid", 32'(rd_valid), 32'h0);
        rd_req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk($sformatf("full_data%0d", i),  32'(rd_data),  32'(exp_a[i]));
            chk($sformatf("full_valid%0d", i), 32'(rd_valid), 32'h1);
            chk($sformatf("full_busy%0d", i),  32'(busy),     (i < 7) ? 32'h1 : 32'h0);
        end
        rd_req = 1'b0;
        cyc();
        chk("hold_rd_valid", 32'(rd_valid), 32'h0);
        chk("hold_rd_data",  32'(rd_data),  32'h44);

        // Re-snapshot in the middle of a transfer restarts at byte 0.
        cnt      = 64'h4444_3333_2222_1111;
        snap_req = 1'b1;
        cyc();
        snap_req = 1'b0;
        rd_req   = 1'b1;
        cyc();
        cyc();
        cyc();
        chk("resnap_pre_data", 32'(rd_data), 32'h22);
        rd_req   = 1'b0;
        cnt      = 64'hDDCC_BBAA_9988_7766;
        snap_req = 1'b1;
        cyc();
        snap_req = 1'b0;
        rd_req   = 1'b1;
        cyc();
        chk("resnap_byte0", 32'(rd_data), 32'h66);
        cyc();
        chk("resnap_byte1", 32'(rd_data), 32'h77);
        rd_req = 1'b0;

        // snap_req and rd_req together: the read is dropped.
        snap_req = 1'b1;
        rd_req   = 1'b1;
        cyc();
        snap_req = 1'b0;
        chk("both_rd_valid", 32'(rd_valid), 32'h0);
        chk("both_rd_err",   32'(rd_err),   32'h0);
        chk("both_busy",     32'(busy),     32'h1);
        cyc();
        rd_req = 1'b0;
        chk("both_next_valid", 32'(rd_valid), 32'h1);
        chk("both_next_data",  32'(rd_data),  32'h66);

        // Reset mid-transfer, asserted together with snap_req and rd_req.
        cnt      = 64'h4444_3333_2222_1111;
        snap_req = 1'b1;
        cyc();
        snap_req = 1'b0;
        rd_req   = 1'b1;
        cyc();
        cyc();
        chk("abort_pre_data", 32'(rd_data), 32'h11);
        rst      = 1'b1;
        snap_req = 1'b1;
        cyc();
        rst      = 1'b0;
        snap_req = 1'b0;
        chk("abort_rd_valid", 32'(rd_valid), 32'h0);
        chk("abort_busy",     32'(busy),     32'h0);
        chk("abort_rd_data",  32'(rd_data),  32'h00);
        cyc();
        rd_req = 1'b0;
        chk("abort_rd_err",      32'(rd_err),   32'h1);
        chk("abort_err_valid",   32'(rd_valid), 32'h0);

        // Counter 0 wrapping from 0xFFFE to 0x0003 across two snapshots.
        cnt      = 64'h0000_0000_0000_FFFE;
        snap_req = 1'b1;
        cyc();
        cnt      = 64'h0000_0000_0000_0003;
        cyc();
        snap_req = 1'b0;
        rd_req   = 1'b1;
        cyc();
`ifdef ENC_READOUT_DELTA_EN
        chk("wrap_byte0", 32'(rd_data), 32'h05);
`else
        chk("wrap_byte0", 32'(rd_data), 32'h03);
`endif
        cyc();
        rd_req = 1'b0;
        chk("wrap_byte1", 32'(rd_data), 32'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_enc_readout_arbiter
`default_nettype wire

// File: doc/enc_readout_arbiter.md
ENC_READOUT_ARBITER -- requirements
Module: enc_readout_arbiter

Interface
REQ-001 SHALL have parameter NCNT, default 4, meaning number of encoder counters served (1..8).
REQ-002 SHALL have parameter WIDTH, default 16, meaning counter width in bits (multiple of 8, 8..32).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-005 SHALL have port cnt  input  NCNT*WIDTH  live counter values; counter k in bits [k*WIDTH +: WIDTH].
REQ-006 SHALL have port snap_req  input  1  host request to latch all counters atomically.
REQ-007 SHALL have port rd_req  input  1  host byte read strobe, one byte per asserted cycle.
REQ-008 SHALL have port rd_data  output  8  returned byte.
REQ-009 SHALL have port rd_valid  output  1  one-cycle pulse qualifying rd_data.
REQ-010 SHALL have port rd_err  output  1  one-cycle pulse: read with no snapshot pending.
REQ-011 SHALL have port busy  output  1  high while a snapshot remains unread.

Function
REQ-012 SHALL implement FSM states IDLE and SERVE; reset state IDLE.
REQ-013 In any state, snap_req SHALL latch all NCNT counters in the same edge, clear the byte pointer and enter SERVE.
REQ-014 In SERVE, rd_req SHALL present byte at pointer on rd_data with rd_valid high the next cycle (latency 1), then increment the pointer.
REQ-015 Byte order SHALL be counter 0 first, little-endian within each counter; total NBYTES = NCNT*WIDTH/8.
REQ-016 After the byte at pointer NBYTES-1 is read, SHALL return to IDLE and drop busy the same edge.
REQ-017 rd_req in IDLE SHALL give rd_data=0x00, rd_valid=0, rd_err=1 one cycle later; state unchanged.
REQ-018 snap_req and rd_req in the same cycle: snap_req SHALL win; rd_req ignored (no rd_valid, no rd_err).
REQ-019 snap_req in SERVE SHALL discard unread bytes and restart from byte 0 with fresh values.
REQ-020 rd_data SHALL hold its last value when rd_valid is low, except after rd_err (0x00).
REQ-021 Snapshot registers SHALL be unaffected by cnt changes between snapshots.

Reset
REQ-022 rst SHALL force state IDLE, pointer 0, rd_data 0x00, rd_valid 0, rd_err 0, busy 0, snapshot and previous-snapshot registers 0.
REQ-023 rst asserted mid-SERVE SHALL abort the transfer; no rd_valid on the following cycle.
REQ-024 rst SHALL take priority over snap_req and rd_req on the same edge.

Configuration
REQ-025 Macro ENC_READOUT_DELTA_EN defined: served value SHALL be cnt minus previous snapshot, modulo 2^WIDTH (wrap-around two's complement), previous snapshot updated on every snap_req.
REQ-026 Macro ENC_READOUT_DELTA_EN undefined: served value SHALL be the absolute latched cnt; previous-snapshot registers not instantiated.

Structure
REQ-027 Shared package enc_readout_pkg SHALL hold the FSM state typedef, NBYTES derivation function and default NCNT/WIDTH constants.
REQ-028 Sub-module enc_snapshot_bank SHALL contain the snapshot/previous registers, delta subtractors and byte-select mux; FSM and pointer remain in top.

Verification
REQ-029 NCNT=4, WIDTH=16, cnt={0x4444,0x3333,0x2222,0x1111}, snap_req, 8 rd_req -> bytes 11,11,22,22,33,33,44,44, busy low after 8th.
REQ-030 rd_req after reset, no snapshot -> rd_err pulse, rd_data 0x00, no rd_valid.
REQ-031 snap_req, 3 reads, cnt changed, snap_req -> next read returns byte 0 of new values.
REQ-032 snap_req and rd_req asserted same cycle -> no rd_valid next cycle; pointer 0, busy high.
REQ-033 DELTA_EN: snap with counter0=0xFFFE, then counter0=0x0003, snap -> counter0 bytes 05,00.
REQ-034 rst asserted after 2 of 8 reads -> IDLE, busy 0, subsequent rd_req gives rd_err.
